// File: rtl/vend_disp_pkg.sv
// Shared types for the vending dispense sequencer: FSM states, action-mask bit
// positions and the priority picker used to choose the next action.
package vend_disp_pkg;

  typedef enum logic [1:0] {IDLE, REQ, REL, FAULT} state_e;

  localparam int ACT_MOTOR = 0;
  localparam int ACT_5C    = 1;
  localparam int ACT_10C   = 2;
  localparam int ACT_N     = 3;

  // Lowest set bit wins, which gives motor > 5c > 10c.
  function automatic logic [ACT_N-1:0] first_act(input logic [ACT_N-1:0] m);
    return m & (~m + 3'd1);
  endfunction

endpackage

// File: rtl/vend_evt_fifo.sv
// Small event queue for action masks. Pointers carry one extra wrap bit so that
// full and empty are distinguished. A push while full is accepted only when a
// pop happens in the same cycle.
module vend_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/vend_dispense_sequencer.sv
// Queues vend/change pulses and plays them out on the motor and coin hoppers over
// four-phase req/ack, tracking coin inventory. VEND_DISP_TIMEOUT_EN adds a watchdog.
module vend_dispense_sequencer
  import vend_disp_pkg::*;
#(
  parameter int QDEPTH     = 4,
  parameter int CNT_W      = 8,
  parameter int INIT_5C    = 20,
  parameter int INIT_10C   = 20,
  parameter int LOW_THRESH = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vend,
  input  logic             change_5C,
  input  logic             change_10C,
  input  logic             refill,
  output logic             motor_req,
  input  logic             motor_ack,
  output logic             hop5_req,
  input  logic             hop5_ack,
  output logic             hop10_req,
  input  logic             hop10_ack,
  output logic             busy,
  output logic             q_full,
  output logic             overflow,
  output logic             short_change,
  output logic             exact_change_only,
  output logic             fault,
  output logic [CNT_W-1:0] cnt_5c,
  output logic [CNT_W-1:0] cnt_10c
);
  localparam logic [CNT_W-1:0] INIT5  = CNT_W'(INIT_5C);
  localparam logic [CNT_W-1:0] INIT10 = CNT_W'(INIT_10C);
  localparam logic [CNT_W-1:0] LOW    = CNT_W'(LOW_THRESH);

  state_e           state, nstate;
  logic [ACT_N-1:0] cur_mask, nmask, q_dout, act_oh, nact_oh, ack_vec, req_vec, req_n;
  logic             q_empty, push, pop, skip, nskip, act_ack;
  logic [CNT_W-1:0] cnt5_n, cnt10_n;

  assign push = vend | change_5C | change_10C;
  assign pop  = (state == IDLE) && !q_empty;

  vend_evt_fifo #(.DEPTH(QDEPTH), .W(ACT_N)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({change_10C, change_5C, vend}),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );

  assign ack_vec = {hop10_ack, hop5_ack, motor_ack};
  assign act_oh  = first_act(cur_mask);
  assign act_ack = |(act_oh & ack_vec);
  // A coin due from an empty hopper is retired without ever raising its req.
  assign skip    = (act_oh[ACT_5C] && cnt_5c == '0) || (act_oh[ACT_10C] && cnt_10c == '0);

  assign busy              = (state != IDLE) || !q_empty;
  assign exact_change_only = (cnt_5c < LOW) || (cnt_10c < LOW);
  assign {hop10_req, hop5_req, motor_req} = req_vec;

`ifdef VEND_DISP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;
  assign wd_hit = (state == REQ || state == REL) && (wd_cnt == WD_W'(TIMEOUT - 1));
`endif

  always_comb begin
    nstate = state;
    nmask  = cur_mask;
    case (state)
      IDLE: if (!q_empty) begin
        nstate = REQ;
        nmask  = q_dout;
      end
      REQ: begin
        if (skip) begin
          nmask  = cur_mask & ~act_oh;
          nstate = (nmask == '0) ? IDLE : REQ;
        end else if (act_ack) begin
          nstate = REL;
        end
      end
      REL: if (!act_ack) begin
        nmask  = cur_mask & ~act_oh;
        nstate = (nmask == '0) ? IDLE : REQ;
      end
      default: ;
    endcase
`ifdef VEND_DISP_TIMEOUT_EN
    if (wd_hit) nstate = FAULT;
`endif
  end

  always_comb begin
    cnt5_n  = cnt_5c;
    cnt10_n = cnt_10c;
    if (refill) begin
      cnt5_n  = INIT5;
      cnt10_n = INIT10;
    end else if (state == REQ && nstate == REL) begin
      if (act_oh[ACT_5C]  && cnt_5c  != '0) cnt5_n  = cnt_5c  - 1'b1;
      if (act_oh[ACT_10C] && cnt_10c != '0) cnt10_n = cnt_10c - 1'b1;
    end
  end

  // Reqs are registered: decide next cycle's req from next mask and next counts.
  assign nact_oh = first_act(nmask);
  assign nskip   = (nact_oh[ACT_5C] && cnt5_n == '0) || (nact_oh[ACT_10C] && cnt10_n == '0);
  assign req_n   = (nstate == REQ && !nskip) ? nact_oh : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cur_mask     <= '0;
      req_vec      <= '0;
      cnt_5c       <= INIT5;
      cnt_10c      <= INIT10;
      overflow     <= 1'b0;
      short_change <= 1'b0;
    end else begin
      state    <= nstate;
      cur_mask <= nmask;
      req_vec  <= req_n;
      cnt_5c   <= cnt5_n;
      cnt_10c  <= cnt10_n;
      if (push && q_full && !pop) overflow <= 1'b1;
      if (state == REQ && skip)   short_change <= 1'b1;
    end
  end

`ifdef VEND_DISP_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      fault  <= 1'b0;
    end else begin
      if (nstate != state || nmask != cur_mask) wd_cnt <= '0;
      else if (state == REQ || state == REL)    wd_cnt <= wd_cnt + 1'b1;
      if (nstate == FAULT) fault <= 1'b1;
    end
  end
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Bench for vend_dispense_sequencer: directed table, corner sequences and a
// randomized run checked against a transaction-level model of the action stream.
module tb_vend_dispense_sequencer;
  localparam int I5  = 3;
  localparam int I10 = 4;
  localparam int LT  = 2;

  logic clk = 0, rst = 1;
  logic vend = 0, change_5C = 0, change_10C = 0, refill = 0;
  logic motor_ack = 0, hop5_ack = 0, hop10_ack = 0;
  logic motor_req, hop5_req, hop10_req, busy, q_full, overflow, short_change;
  logic exact_change_only, fault;
  logic [7:0] cnt_5c, cnt_10c;

  int checks = 0, errors = 0, ack_mode = 0, multi_req = 0;
  int obs[$];

  typedef struct {
    logic [2:0] mask;
    int         busy_cyc;
    int         cnt5;
    int         cnt10;
  } vec_t;
  vec_t tbl[7];

  vend_dispense_sequencer #(
    .QDEPTH(4), .CNT_W(8), .INIT_5C(I5), .INIT_10C(I10), .LOW_THRESH(LT), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .vend(vend), .change_5C(change_5C), .change_10C(change_10C),
    .refill(refill), .motor_req(motor_req), .motor_ack(motor_ack), .hop5_req(hop5_req),
    .hop5_ack(hop5_ack), .hop10_req(hop10_req), .hop10_ack(hop10_ack), .busy(busy),
    .q_full(q_full), .overflow(overflow), .short_change(short_change),
    .exact_change_only(exact_change_only), .fault(fault), .cnt_5c(cnt_5c), .cnt_10c(cnt_10c)
  );

  always #5 clk = ~clk;

  // Actuator model: 0 = ack mirrors req, 1 = stalled, 2 = random-delay follower.
  initial forever begin
    @(negedge clk);
    case (ack_mode)
      0: begin motor_ack = motor_req; hop5_ack = hop5_req; hop10_ack = hop10_req; end
      1: begin motor_ack = 0; hop5_ack = 0; hop10_ack = 0; end
      default: begin
        if (motor_ack != motor_req && $urandom_range(0, 2) == 0) motor_ack = motor_req;
        if (hop5_ack  != hop5_req  && $urandom_range(0, 2) == 0) hop5_ack  = hop5_req;
        if (hop10_ack != hop10_req && $urandom_range(0, 2) == 0) hop10_ack = hop10_req;
      end
    endcase
  end

  // Record each started action (req rising) as 0=motor, 1=5c, 2=10c.
  initial begin
    logic pm = 0, p5 = 0, p10 = 0;
    forever begin
      @(negedge clk);
      if (motor_req && !pm) obs.push_back(0);
      if (hop5_req  && !p5) obs.push_back(1);
      if (hop10_req && !p10) obs.push_back(2);
      if (int'(motor_req) + int'(hop5_req) + int'(hop10_req) > 1) multi_req++;
      pm = motor_req; p5 = hop5_req; p10 = hop10_req;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp_seq(input string nm, input int exp[$]);
    chk({nm, "_len"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < obs.size(); i++)
      chk($sformatf("%s_act%0d", nm, i), obs[i], exp[i]);
  endtask

  task automatic send(input logic [2:0] m);
    @(negedge clk); {change_10C, change_5C, vend} = m;
    @(negedge clk); {change_10C, change_5C, vend} = 3'b000;
  endtask

  task automatic wait_idle(input string nm, output int n);
    n = 0;
    while (busy && n < 3000) begin n++; @(negedge clk); end
    chk({nm, "_drained"}, busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    obs.delete();
  endtask

  task automatic pulse_refill();
    @(negedge clk); refill = 1;
    @(negedge clk); refill = 0;
  endtask

  initial begin
    int n, m5, m10, sh;
    int exp[$];
    int mq[$];
    int ovm[6];
    logic [2:0] m;

    tbl = '{'{3'b001, 3, 3, 4}, '{3'b010, 3, 2, 4}, '{3'b011, 5, 2, 4}, '{3'b100, 3, 3, 3},
            '{3'b101, 5, 3, 3}, '{3'b110, 5, 2, 3}, '{3'b111, 7, 2, 3}};
    ovm = '{1, 2, 5, 4, 1, 2};

    #1 rst = 0;
    repeat (2) @(negedge clk);
    chk("rst_motor_req", motor_req, 0);
    chk("rst_hop5_req", hop5_req, 0);
    chk("rst_hop10_req", hop10_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_q_full", q_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_short", short_change, 0);
    chk("rst_fault", fault, 0);
    chk("rst_cnt5", cnt_5c, I5);
    chk("rst_cnt10", cnt_10c, I10);
    chk("rst_exact", exact_change_only, 0);
    @(negedge clk); rst = 1;

    // Single entries, immediate acks: 2 cycles per action plus one idle cycle.
    ack_mode = 0;
    foreach (tbl[v]) begin
      do_reset();
      send(tbl[v].mask);
      wait_idle($sformatf("tbl%0d", v), n);
      chk($sformatf("tbl%0d_busy_cycles", v), n, tbl[v].busy_cyc);
      exp = {};
      for (int b = 0; b < 3; b++) if (tbl[v].mask[b]) exp.push_back(b);
      cmp_seq($sformatf("tbl%0d", v), exp);
      chk($sformatf("tbl%0d_cnt5", v), cnt_5c, tbl[v].cnt5);
      chk($sformatf("tbl%0d_cnt10", v), cnt_10c, tbl[v].cnt10);
    end

    // Overflow: one entry in service, four queued, sixth dropped.
    do_reset();
    ack_mode = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); {change_10C, change_5C, vend} = 3'(ovm[i]);
    end
    @(negedge clk); {change_10C, change_5C, vend} = 3'b000;
    chk("ovf_q_full", q_full, 1);
    chk("ovf_overflow", overflow, 1);
    chk("ovf_stalled_req", motor_req, 1);
    ack_mode = 0;
    wait_idle("ovf", n);
    cmp_seq("ovf", '{0, 1, 0, 2, 2, 0});
    chk("ovf_cnt5", cnt_5c, I5 - 1);
    chk("ovf_cnt10", cnt_10c, I10 - 2);
    chk("ovf_q_full_after", q_full, 0);
    chk("ovf_sticky", overflow, 1);

    // Drain the 5c hopper, then one more 5c is skipped.
    do_reset();
    ack_mode = 0;
    repeat (I5) begin send(3'b010); wait_idle("skip_pre", n); end
    chk("skip_short_before", short_change, 0);
    chk("skip_cnt5_zero", cnt_5c, 0);
    send(3'b010);
    wait_idle("skip", n);
    exp = {};
    repeat (I5) exp.push_back(1);
    cmp_seq("skip", exp);
    chk("skip_short", short_change, 1);
    chk("skip_exact", exact_change_only, 1);
    chk("skip_cnt5_floor", cnt_5c, 0);
    pulse_refill();
    chk("refill_cnt5", cnt_5c, I5);
    chk("refill_cnt10", cnt_10c, I10);
    chk("refill_exact", exact_change_only, 0);
    chk("refill_short_sticky", short_change, 1);

    // Reset in the middle of a 10c handshake with entries still queued.
    do_reset();
    ack_mode = 0;
    send(3'b100);
    wait_idle("mid_pre", n);
    chk("mid_cnt10_dec", cnt_10c, I10 - 1);
    ack_mode = 1;
    send(3'b100); send(3'b001); send(3'b001);
    n = 0;
    while (!hop10_req && n < 20) begin n++; @(negedge clk); end
    chk("mid_hop10_up", hop10_req, 1);
    chk("mid_busy", busy, 1);
    #2 rst = 0;
    #1;
    chk("mid_hop10_dropped", hop10_req, 0);
    chk("mid_busy_clr", busy, 0);
    chk("mid_cnt10_reload", cnt_10c, I10);
    @(negedge clk); rst = 1;
    obs.delete();
    ack_mode = 0;
    repeat (8) @(negedge clk);
    chk("mid_queue_empty", busy, 0);
    chk("mid_no_service", obs.size(), 0);

    // Randomized traffic against a transaction-level model of the action stream.
    sh = 0;
    for (int r = 0; r < 3; r++) begin
      if (r == 0) do_reset();
      else pulse_refill();
      m5 = I5; m10 = I10;
      obs.delete(); mq.delete();
      ack_mode = 2;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        if (!q_full && $urandom_range(0, 3) == 0) begin
          m = 3'($urandom_range(1, 7));
          {change_10C, change_5C, vend} = m;
          mq.push_back(int'(m));
        end else begin
          {change_10C, change_5C, vend} = 3'b000;
        end
      end
      @(negedge clk); {change_10C, change_5C, vend} = 3'b000;
      wait_idle($sformatf("rnd%0d", r), n);
      exp = {};
      foreach (mq[i]) begin
        if (mq[i] % 2 == 1) exp.push_back(0);
        if ((mq[i] / 2) % 2 == 1) begin
          if (m5 > 0) begin exp.push_back(1); m5--; end else sh = 1;
        end
        if (mq[i] / 4 == 1) begin
          if (m10 > 0) begin exp.push_back(2); m10--; end else sh = 1;
        end
      end
      cmp_seq($sformatf("rnd%0d", r), exp);
      chk($sformatf("rnd%0d_cnt5", r), cnt_5c, m5);
      chk($sformatf("rnd%0d_cnt10", r), cnt_10c, m10);
      chk($sformatf("rnd%0d_short", r), short_change, sh);
      chk($sformatf("rnd%0d_exact", r), exact_change_only, int'(m5 < LT || m10 < LT));
      chk($sformatf("rnd%0d_overflow", r), overflow, 0);
    end

    chk("one_req_at_a_time", multi_req, 0);
    chk("fault_tied_low", fault, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
